// File: rtl/mm6532_bus_pkg.sv
// Shared codes for the RIOT bus master: command opcodes, FSM states, chip-select values, slave map.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mm6532_bus_pkg;

    // Command opcodes carried on CMD_OP
    localparam logic [1:0] OP_WRITE    = 2'b00;
    localparam logic [1:0] OP_READ     = 2'b01;
    localparam logic [1:0] OP_WAIT_IRQ = 2'b10;
    localparam logic [1:0] OP_POLL     = 2'b11;

    // Master sequencing states
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ACCESS = 3'd1,
        S_GAP    = 3'd2,
        S_WAITI  = 3'd3,
        S_RESP   = 3'd4
    } state_t;

    // {CS2_N, CS1}: selected only when CS2_N low and CS1 high
    localparam logic [1:0] CS_SEL  = 2'b01;
    localparam logic [1:0] CS_IDLE = 2'b00;

    // RIOT register map (I/O side, RS_N high)
    localparam logic [6:0] RIOT_DRA        = 7'h00;
    localparam logic [6:0] RIOT_DDRA       = 7'h01;
    localparam logic [6:0] RIOT_DRB        = 7'h02;
    localparam logic [6:0] RIOT_DDRB       = 7'h03;
    localparam logic [6:0] RIOT_TIM_1T     = 7'h14;
    localparam logic [6:0] RIOT_TIM_8T     = 7'h15;
    localparam logic [6:0] RIOT_TIM_64T    = 7'h16;
    localparam logic [6:0] RIOT_TIM_1024T  = 7'h17;
    localparam logic [6:0] RIOT_TIM_IRQ_EN = 7'h08;
    localparam logic [6:0] RIOT_TIMER_RD   = 7'h04;
    localparam logic [6:0] RIOT_FLAGS      = 7'h05;

    // Latched command; field order matches the flat concatenation of the command inputs
    typedef struct packed {
        logic [1:0] op;
        logic       ram;
        logic [6:0] a;
        logic [7:0] wd;
        logic [7:0] match;
    } cmd_t;

    // Poll comparison: only the bits selected by the mask take part
    function automatic logic poll_hit(input logic [7:0] data,
                                      input logic [7:0] mask,
                                      input logic [7:0] match);
        return ((data & mask) == match);
    endfunction

endpackage

// File: rtl/mm6532_bus_master_ctr.sv
// Saturating wait/poll cycle counter with a timeout compare.
// Latency: count updates one cycle after clr/inc; expired is combinational on the count.
// Backpressure: none; saturates at all-ones instead of wrapping.
module bus_timeout_ctr #(
    parameter int TIMEOUT = 1024,
    parameter int TW      = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic expired
);

    logic [TW-1:0] count;

    // Clear wins over increment; holding at all-ones keeps a long wait from looking fresh again
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + TW'(1);
        end
    end

    // A zero limit means the wait is unbounded
    assign expired = (TIMEOUT != 0) && (count >= TW'(TIMEOUT));

endmodule

// File: rtl/mm6532_bus_master.sv
// Command-driven initiator for one 6532 RIOT: single accesses, wait-for-IRQ, poll-until-match.
// Latency: accept at edge N, bus cycle right after N, RSP_VALID after edge N+1 (3-cycle spacing).
// Backpressure: CMD_READY only in IDLE; response held stable until RSP_READY.
module mm6532_bus_master
    import mm6532_bus_pkg::*;
#(
    parameter int TIMEOUT = 1024,
    parameter int TW      = 16
) (
    input  logic       CLK,
    input  logic       RES,
    input  logic       CMD_VALID,
    output logic       CMD_READY,
    input  logic [1:0] CMD_OP,
    input  logic       CMD_RAM,
    input  logic [6:0] CMD_A,
    input  logic [7:0] CMD_WD,
    input  logic [7:0] CMD_MATCH,
    output logic       RSP_VALID,
    input  logic       RSP_READY,
    output logic [7:0] RSP_RD,
    output logic       RSP_TIMEOUT,
    output logic       R_W,
    output logic [1:0] CS,
    output logic       RS_N,
    output logic [6:0] A,
    output logic [7:0] D_OUT,
    input  logic [7:0] D_IN,
    input  logic       IRQ_N
);

    state_t     state, state_nxt;
    cmd_t       cmd_in, cmd_q, bus_cmd;
    logic       accept;
    logic       ctr_clr, ctr_inc, ctr_expired;
    logic       irq_q;
    logic [7:0] rsp_rd_q, rsp_rd_nxt;
    logic       rsp_to_q, rsp_to_nxt;
    logic [1:0] cs_q, cs_nxt;
    logic       r_w_q, r_w_nxt;
    logic       rs_n_q, rs_n_nxt;
    logic [6:0] a_q, a_nxt;
    logic [7:0] d_out_q, d_out_nxt;

    assign cmd_in = {CMD_OP, CMD_RAM, CMD_A, CMD_WD, CMD_MATCH};
    assign accept = CMD_VALID && (state == S_IDLE);

    // The access following acceptance uses the live command; later poll re-reads use the latched one
    assign bus_cmd = (state == S_IDLE) ? cmd_in : cmd_q;

    bus_timeout_ctr #(
        .TIMEOUT (TIMEOUT),
        .TW      (TW)
    ) u_ctr (
        .clk     (CLK),
        .rst     (RES),
        .clr     (ctr_clr),
        .inc     (ctr_inc),
        .expired (ctr_expired)
    );

    // Next state, counter control and response capture
    always_comb begin
        state_nxt  = state;
        ctr_clr    = 1'b0;
        ctr_inc    = 1'b0;
        rsp_rd_nxt = rsp_rd_q;
        rsp_to_nxt = rsp_to_q;
        case (state)
            S_IDLE: begin
                if (CMD_VALID) begin
                    ctr_clr   = 1'b1;
                    state_nxt = (CMD_OP == OP_WAIT_IRQ) ? S_WAITI : S_ACCESS;
                end
            end
            S_ACCESS: begin
                rsp_to_nxt = 1'b0;
                case (cmd_q.op)
                    OP_WRITE: begin
                        rsp_rd_nxt = 8'h00;
                        state_nxt  = S_RESP;
                    end
                    OP_READ: begin
                        rsp_rd_nxt = D_IN;
                        state_nxt  = S_RESP;
                    end
                    OP_POLL: begin
                        rsp_rd_nxt = D_IN;
                        if (poll_hit(D_IN, cmd_q.wd, cmd_q.match)) begin
                            state_nxt = S_RESP;
                        end else if (ctr_expired) begin
                            rsp_to_nxt = 1'b1;
                            state_nxt  = S_RESP;
                        end else begin
                            state_nxt = S_GAP;
                        end
                    end
                    default: begin
                        rsp_rd_nxt = 8'h00;
                        state_nxt  = S_RESP;
                    end
                endcase
            end
            S_GAP: begin
                ctr_inc   = 1'b1;
                state_nxt = S_ACCESS;
            end
            S_WAITI: begin
                ctr_inc = 1'b1;
                // IRQ is checked first so it wins a tie with expiry
                if (!irq_q) begin
                    rsp_rd_nxt = 8'h00;
                    rsp_to_nxt = 1'b0;
                    state_nxt  = S_RESP;
                end else if (ctr_expired) begin
                    rsp_rd_nxt = 8'h00;
                    rsp_to_nxt = 1'b1;
                    state_nxt  = S_RESP;
                end
            end
            S_RESP: begin
                if (RSP_READY) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Bus values for the coming cycle: driven only when that cycle is an access, idle otherwise
    always_comb begin
        cs_nxt    = CS_IDLE;
        r_w_nxt   = 1'b1;
        rs_n_nxt  = 1'b1;
        a_nxt     = 7'h00;
        d_out_nxt = 8'h00;
        if (state_nxt == S_ACCESS) begin
            cs_nxt   = CS_SEL;
            rs_n_nxt = !bus_cmd.ram;
            a_nxt    = bus_cmd.a;
            if (bus_cmd.op == OP_WRITE) begin
                r_w_nxt   = 1'b0;
                d_out_nxt = bus_cmd.wd;
            end
        end
    end

    // State, latched command and synchronised IRQ
    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            state <= S_IDLE;
            cmd_q <= '0;
            irq_q <= 1'b1;
        end else begin
            state <= state_nxt;
            irq_q <= IRQ_N;
            if (accept) begin
                cmd_q <= cmd_in;
            end
        end
    end

    // Registered bus and response outputs; reset drops the bus to idle immediately
    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            cs_q     <= CS_IDLE;
            r_w_q    <= 1'b1;
            rs_n_q   <= 1'b1;
            a_q      <= 7'h00;
            d_out_q  <= 8'h00;
            rsp_rd_q <= 8'h00;
            rsp_to_q <= 1'b0;
        end else begin
            cs_q     <= cs_nxt;
            r_w_q    <= r_w_nxt;
            rs_n_q   <= rs_n_nxt;
            a_q      <= a_nxt;
            d_out_q  <= d_out_nxt;
            rsp_rd_q <= rsp_rd_nxt;
            rsp_to_q <= rsp_to_nxt;
        end
    end

    assign CMD_READY   = (state == S_IDLE);
    assign RSP_VALID   = (state == S_RESP);
    assign RSP_RD      = rsp_rd_q;
    assign RSP_TIMEOUT = rsp_to_q;
    assign CS          = cs_q;
    assign R_W         = r_w_q;
    assign RS_N        = rs_n_q;
    assign A           = a_q;
    assign D_OUT       = d_out_q;

endmodule
